// File: rtl/aes_key_expand_seq.sv
// Sequential AES key schedule for 128/192/256-bit keys: one 32-bit word per cycle, S-box lookups combinational.
// Done pulses N-Nk cycles after the accepting edge; start is ignored while the schedule is being produced.
module aes_key_expand_seq (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [255:0]  key,
    input  logic [1:0]    size,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [1919:0] key_out
);

    typedef enum logic {IDLE, EXPAND} state_t;

    // Byte b lives at bits [8*(255-b) +: 8], so entry 0 is the MSB byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    state_t      state;
    state_t      state_nxt;
    logic [31:0] w_mem [0:63];
    logic [5:0]  idx;
    logic [2:0]  phase;
    logic [2:0]  phase_nxt;
    logic [3:0]  nk_q;
    logic [5:0]  last_q;
    logic [7:0]  rcon;
    logic [3:0]  nk_in;
    logic [5:0]  last_in;
    logic        size_ok;
    logic        last_step;
    logic [31:0] prev_word;
    logic [31:0] back_word;
    logic [31:0] temp;
    logic [31:0] new_word;

    always_comb begin
        nk_in   = 4'd4;
        last_in = 6'd43;
        size_ok = 1'b1;
        case (size)
            2'b00: begin
                nk_in   = 4'd4;
                last_in = 6'd43;
            end
            2'b01: begin
                nk_in   = 4'd6;
                last_in = 6'd51;
            end
            2'b10: begin
                nk_in   = 4'd8;
                last_in = 6'd59;
            end
            default: size_ok = 1'b0;
        endcase
    end

    assign last_step = (idx == last_q);
    assign prev_word = w_mem[idx - 6'd1];
    assign back_word = w_mem[idx - {2'b00, nk_q}];
    assign phase_nxt = ({1'b0, phase} == nk_q - 4'd1) ? 3'd0 : phase + 3'd1;

    // phase tracks i mod Nk, so no division is needed to pick the temp rule.
    always_comb begin
        temp = prev_word;
        if (phase == 3'd0) begin
            temp = sub_word({prev_word[23:0], prev_word[31:24]}) ^ {rcon, 24'h000000};
        end else if (nk_q == 4'd8 && phase == 3'd4) begin
            temp = sub_word(prev_word);
        end
    end

    assign new_word = back_word ^ temp;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && size_ok) state_nxt = EXPAND;
            EXPAND:  if (last_step) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == EXPAND);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < 64; j++) w_mem[j] <= '0;
            idx    <= '0;
            phase  <= '0;
            rcon   <= 8'h01;
            nk_q   <= '0;
            last_q <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !size_ok) begin
                        err <= 1'b1;
                    end else if (start) begin
                        for (int j = 0; j < 8; j++)
                            w_mem[j] <= (j < int'(nk_in)) ? key[255-32*j -: 32] : 32'h0;
                        for (int j = 8; j < 64; j++) w_mem[j] <= '0;
                        idx    <= {2'b00, nk_in};
                        phase  <= '0;
                        rcon   <= 8'h01;
                        nk_q   <= nk_in;
                        last_q <= last_in;
                    end
                end
                EXPAND: begin
                    w_mem[idx] <= new_word;
                    idx        <= idx + 6'd1;
                    phase      <= phase_nxt;
                    if (phase == 3'd0)
                        rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
                    if (last_step) done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        key_out = '0;
        for (int j = 0; j < 60; j++) key_out[1919-32*j -: 32] = w_mem[j];
    end

endmodule
